// File: rtl/gs_acq_sequencer_if.sv
// Command/ROM/sample/status bundle for gs_acq_sequencer.
// master = sequencer side, slave = host FIFOs and signal ROM side.
interface gs_acq_sequencer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned SEL_W  = 2
);
  logic [31:0]       iCmdData;
  logic              iCmdEmpty;
  logic              oCmdRd;
  logic              iAbort;
  logic [ADDR_W-1:0] oAddr;
  logic [SEL_W-1:0]  oSignSelec;
  logic [DATA_W-1:0] i16Reg;
  logic              oOutWr;
  logic [DATA_W-1:0] oOutData;
  logic              iOutFull;
  logic              oStatWr;
  logic [31:0]       oStatData;
  logic              iStatFull;
  logic              oBusy;

  modport master (
    input  iCmdData, iCmdEmpty, iAbort, i16Reg, iOutFull, iStatFull,
    output oCmdRd, oAddr, oSignSelec, oOutWr, oOutData, oStatWr, oStatData, oBusy
  );

  modport slave (
    output iCmdData, iCmdEmpty, iAbort, i16Reg, iOutFull, iStatFull,
    input  oCmdRd, oAddr, oSignSelec, oOutWr, oOutData, oStatWr, oStatData, oBusy
  );
endinterface

// File: rtl/gs_acq_sequencer.sv
// GS acquisition sequencer: pops commands, streams ROM samples to the raw FIFO, posts one status word per command.
// Optional GS_ACQ_BYTESWAP_EN: byte-reverse output samples and flag it in status bits [15:12].
module gs_acq_sequencer #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic               iClk,
  input  logic               iReset,
  gs_acq_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_WAIT, S_PUSH, S_STATUS
  } state_t;

  localparam logic [2:0] LAT = 3'(ROM_LAT);

  state_t            state, state_n;
  logic [31:0]       cmd_q;
  logic [7:0]        code_q, code_n;
  logic [11:0]       written_q, written_inc;
  logic [2:0]        lat_cnt;
  logic [DATA_W-1:0] hold_q, last_q, push_data;
  logic [ADDR_W-1:0] addr_q;
  logic [SEL_W-1:0]  sel_q;
  logic              cmd_rd, out_wr, stat_wr, capture, set_code;
  logic [3:0]        swap_flag;

`ifdef GS_ACQ_BYTESWAP_EN
  always_comb begin
    push_data = '0;
    for (int unsigned b = 0; b < DATA_W / 8; b++) begin
      push_data[8*b +: 8] = hold_q[DATA_W - 8 - 8*b +: 8];
    end
  end
  assign swap_flag = 4'h1;
`else
  assign push_data = hold_q;
  assign swap_flag = 4'h0;
`endif

  assign written_inc = written_q + 12'd1;

  always_ff @(posedge iClk) begin
    if (iReset) state <= S_IDLE;
    else        state <= state_n;
  end

  // Abort takes priority over both the ROM capture and the FIFO write.
  always_comb begin
    state_n  = state;
    cmd_rd   = 1'b0;
    out_wr   = 1'b0;
    stat_wr  = 1'b0;
    capture  = 1'b0;
    set_code = 1'b0;
    code_n   = '0;
    unique case (state)
      S_IDLE:  if (!bus.iCmdEmpty) state_n = S_FETCH;
      S_FETCH: begin
        cmd_rd  = 1'b1;
        state_n = S_DECODE;
      end
      S_DECODE: begin
        state_n  = S_STATUS;
        set_code = 1'b1;
        if (cmd_q[31:28] != 4'h1)                      code_n = 8'h04;
        else if ({1'b0, cmd_q[27:24]} >= 5'(NUM_CH))   code_n = 8'h01;
        else if (cmd_q[11:0] == '0)                    code_n = 8'h02;
        else begin
          set_code = 1'b0;
          state_n  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.iAbort) begin
          set_code = 1'b1;
          code_n   = 8'h03;
          state_n  = S_STATUS;
        end else if (lat_cnt == LAT) begin
          capture = 1'b1;
          state_n = S_PUSH;
        end
      end
      S_PUSH: begin
        if (bus.iAbort) begin
          set_code = 1'b1;
          code_n   = 8'h03;
          state_n  = S_STATUS;
        end else if (!bus.iOutFull) begin
          out_wr = 1'b1;
          if (written_inc == cmd_q[11:0]) begin
            set_code = 1'b1;
            code_n   = 8'h00;
            state_n  = S_STATUS;
          end else begin
            state_n = S_WAIT;
          end
        end
      end
      S_STATUS: begin
        if (!bus.iStatFull) begin
          stat_wr = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      cmd_q     <= '0;
      code_q    <= '0;
      written_q <= '0;
      lat_cnt   <= '0;
      hold_q    <= '0;
      last_q    <= '0;
      addr_q    <= '0;
      sel_q     <= '0;
    end else begin
      if (cmd_rd) begin
        cmd_q     <= bus.iCmdData;
        written_q <= '0;
      end
      if (state == S_DECODE && state_n == S_WAIT) begin
        addr_q <= ADDR_W'(cmd_q[23:12]);
        sel_q  <= SEL_W'(cmd_q[27:24]);
      end
      lat_cnt <= (state == S_WAIT && state_n == S_WAIT) ? lat_cnt + 3'd1 : '0;
      if (capture) hold_q <= bus.i16Reg;
      if (out_wr) begin
        last_q    <= push_data;
        written_q <= written_inc;
        addr_q    <= addr_q + ADDR_W'(1);
      end
      if (set_code) code_q <= code_n;
    end
  end

  assign bus.oCmdRd     = cmd_rd;
  assign bus.oAddr      = addr_q;
  assign bus.oSignSelec = sel_q;
  assign bus.oOutWr     = out_wr;
  assign bus.oOutData   = out_wr ? push_data : last_q;
  assign bus.oStatWr    = stat_wr;
  assign bus.oStatData  = stat_wr ? {cmd_q[31:24], code_q, swap_flag, written_q} : '0;
  assign bus.oBusy      = (state != S_IDLE);

endmodule

// File: tb/tb_gs_acq_sequencer.sv
// Directed bench for gs_acq_sequencer with FWFT command FIFO, latency-1 ROM model and sample/status scoreboards.
module tb_gs_acq_sequencer;

  logic clk;
  logic iReset;

  gs_acq_sequencer_if #(.DATA_W(16), .ADDR_W(8), .SEL_W(2)) bus ();

  gs_acq_sequencer #(
    .DATA_W(16), .ADDR_W(8), .NUM_CH(4), .SEL_W(2), .ROM_LAT(1)
  ) dut (
    .iClk  (clk),
    .iReset(iReset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_wr     = 0;
  int n_stat   = 0;
  int n_rd     = 0;
  int n_pop    = 0;
  int cyc      = 0;

  logic [31:0] cmdq[$];
  logic [15:0] exp_samp[$];
  logic [31:0] exp_stat[$];
  int          wr_cycles[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  function automatic logic [15:0] rom(input logic [1:0] sel, input logic [7:0] a);
    return {4'hA, 2'b00, sel, a};
  endfunction

  function automatic logic [15:0] exp_sample(input logic [1:0] sel, input logic [7:0] a);
    logic [15:0] d;
    d = rom(sel, a);
`ifdef GS_ACQ_BYTESWAP_EN
    return {d[7:0], d[15:8]};
`else
    return d;
`endif
  endfunction

  function automatic logic [31:0] stat(input logic [3:0] op, input logic [3:0] ch,
                                       input logic [7:0] code, input logic [11:0] cnt);
`ifdef GS_ACQ_BYTESWAP_EN
    return {op, ch, code, 4'h1, cnt};
`else
    return {op, ch, code, 4'h0, cnt};
`endif
  endfunction

  // Signal ROM with one cycle of latency.
  always @(posedge clk) bus.i16Reg <= rom(bus.oSignSelec, bus.oAddr);

  // FWFT command FIFO: pops land just after the edge that ended the oCmdRd cycle.
  initial begin
    bus.iCmdEmpty = 1'b1;
    bus.iCmdData  = '0;
    forever begin
      @(posedge clk);
      #2;
      while (n_pop < n_rd) begin
        if (cmdq.size() != 0) void'(cmdq.pop_front());
        n_pop++;
      end
      bus.iCmdEmpty = (cmdq.size() == 0);
      bus.iCmdData  = (cmdq.size() == 0) ? 32'h0 : cmdq[0];
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (bus.oCmdRd) begin
      n_rd++;
      check("rd_when_empty", 32'(bus.iCmdEmpty), 32'h0);
    end
    if (bus.oOutWr || bus.oStatWr)
      check("wr_stat_exclusive", 32'(bus.oOutWr & bus.oStatWr), 32'h0);
    if (bus.oOutWr) begin
      n_wr++;
      wr_cycles.push_back(cyc);
      check("wr_when_full", 32'(bus.iOutFull), 32'h0);
      if (exp_samp.size() == 0) check("sample_expected", 32'(exp_samp.size()), 32'h1);
      else check("sample", 32'(bus.oOutData), 32'(exp_samp.pop_front()));
    end
    if (bus.oStatWr) begin
      n_stat++;
      if (exp_stat.size() == 0) check("status_expected", 32'(exp_stat.size()), 32'h1);
      else check("status", bus.oStatData, exp_stat.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_wr(input int target, input string tag);
    int b = 0;
    while (n_wr < target && b < 1000) begin tick(1); b++; end
    check(tag, 32'(n_wr >= target), 32'h1);
  endtask

  task automatic wait_stat(input int target, input string tag);
    int b = 0;
    while (n_stat < target && b < 1000) begin tick(1); b++; end
    check(tag, 32'(n_stat >= target), 32'h1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 32'({bus.oCmdRd, bus.oOutWr, bus.oStatWr, bus.oBusy, bus.oAddr, bus.oSignSelec}), 32'h0);
    check({tag, "_data"}, 32'(bus.oOutData), 32'h0);
    check({tag, "_stat"}, bus.oStatData, 32'h0);
  endtask

  int st0, w0, rd0;

  initial begin
    bus.iAbort    = 1'b0;
    bus.iOutFull  = 1'b0;
    bus.iStatFull = 1'b0;
    iReset        = 1'b1;
    tick(3);
    check_zero("reset");
    iReset = 1'b0;
    tick(2);

    // Basic run, check spacing of ROM_LAT + 2 cycles.
    st0 = n_stat; w0 = wr_cycles.size();
    cmdq.push_back(32'h1201_0004);
    for (int i = 0; i < 4; i++) exp_samp.push_back(exp_sample(2'd2, 8'(8'h10 + i)));
    exp_stat.push_back(stat(4'h1, 4'h2, 8'h00, 12'd4));
    wait_stat(st0 + 1, "t1_done");
    check("t1_writes", 32'(wr_cycles.size() - w0), 32'd4);
    if (wr_cycles.size() == w0 + 4)
      for (int i = 1; i < 4; i++)
        check("t1_spacing", 32'(wr_cycles[w0+i] - wr_cycles[w0+i-1]), 32'd3);
    tick(2);

    // Address wrap, with status FIFO held full at the end.
    st0 = n_stat; w0 = n_wr;
    bus.iStatFull = 1'b1;
    cmdq.push_back(32'h120F_E004);
    exp_samp.push_back(exp_sample(2'd2, 8'hFE));
    exp_samp.push_back(exp_sample(2'd2, 8'hFF));
    exp_samp.push_back(exp_sample(2'd2, 8'h00));
    exp_samp.push_back(exp_sample(2'd2, 8'h01));
    exp_stat.push_back(stat(4'h1, 4'h2, 8'h00, 12'd4));
    wait_wr(w0 + 4, "t2_writes");
    tick(5);
    check("t2_stat_held", 32'(n_stat - st0), 32'd0);
    check("t2_busy_held", 32'(bus.oBusy), 32'h1);
    bus.iStatFull = 1'b0;
    wait_stat(st0 + 1, "t2_done");
    tick(2);

    // Sample FIFO backpressure on the second sample.
    st0 = n_stat; w0 = n_wr;
    cmdq.push_back(32'h1102_0004);
    for (int i = 0; i < 4; i++) exp_samp.push_back(exp_sample(2'd1, 8'(8'h20 + i)));
    exp_stat.push_back(stat(4'h1, 4'h1, 8'h00, 12'd4));
    wait_wr(w0 + 1, "t3_first");
    bus.iOutFull = 1'b1;
    tick(10);
    check("t3_hold", 32'(n_wr - w0), 32'd1);
    bus.iOutFull = 1'b0;
    wait_stat(st0 + 1, "t3_done");
    check("t3_writes", 32'(n_wr - w0), 32'd4);
    tick(2);

    // Rejected commands.
    st0 = n_stat; w0 = n_wr; rd0 = n_rd;
    cmdq.push_back(32'h1500_0001);
    cmdq.push_back(32'h1100_0000);
    cmdq.push_back(32'h3000_0001);
    exp_stat.push_back(stat(4'h1, 4'h5, 8'h01, 12'd0));
    exp_stat.push_back(stat(4'h1, 4'h1, 8'h02, 12'd0));
    exp_stat.push_back(stat(4'h3, 4'h0, 8'h04, 12'd0));
    wait_stat(st0 + 3, "t4_done");
    tick(2);
    check("t4_rd_pulses", 32'(n_rd - rd0), 32'd3);
    check("t4_no_writes", 32'(n_wr - w0), 32'd0);

    // Abort after the 7th write, then a queued command.
    st0 = n_stat; w0 = n_wr;
    cmdq.push_back(32'h1304_0064);
    cmdq.push_back(32'h1000_0002);
    for (int i = 0; i < 7; i++) exp_samp.push_back(exp_sample(2'd3, 8'(8'h40 + i)));
    exp_stat.push_back(stat(4'h1, 4'h3, 8'h03, 12'd7));
    exp_samp.push_back(exp_sample(2'd0, 8'h00));
    exp_samp.push_back(exp_sample(2'd0, 8'h01));
    exp_stat.push_back(stat(4'h1, 4'h0, 8'h00, 12'd2));
    wait_wr(w0 + 7, "t5_seven");
    bus.iAbort = 1'b1;
    tick(1);
    bus.iAbort = 1'b0;
    wait_stat(st0 + 2, "t5_done");
    check("t5_writes", 32'(n_wr - w0), 32'd9);
    tick(2);

    // Reset mid-run after three writes.
    st0 = n_stat; w0 = n_wr;
    cmdq.push_back(32'h1200_000A);
    for (int i = 0; i < 3; i++) exp_samp.push_back(exp_sample(2'd2, 8'(i)));
    wait_wr(w0 + 3, "t6_three");
    iReset = 1'b1;
    tick(1);
    check_zero("t6_reset");
    iReset = 1'b0;
    tick(6);
    check("t6_no_status", 32'(n_stat - st0), 32'd0);
    check("t6_writes", 32'(n_wr - w0), 32'd3);
    cmdq.push_back(32'h1000_5002);
    exp_samp.push_back(exp_sample(2'd0, 8'h05));
    exp_samp.push_back(exp_sample(2'd0, 8'h06));
    exp_stat.push_back(stat(4'h1, 4'h0, 8'h00, 12'd2));
    wait_stat(st0 + 1, "t6_next_done");
    tick(3);

    check("samples_drained", 32'(exp_samp.size()), 32'd0);
    check("status_drained", 32'(exp_stat.size()), 32'd0);
    check("idle_at_end", 32'(bus.oBusy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
